uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  Serial receiver paired with uart_tx; consumes the txd line (or an external pin) and
//  recovers parallel words. Synchronises the async line, detects start, samples each bit
//  at mid-period, checks parity/stop, and presents each word with a one-cycle valid
//  pulse and error flags. Sits between the board RX pin and the downstream consumer.
// PARAMETERS
//  CHECK_BIT  "None"      parity: "None" none, "Odd" odd, "Even" even
//  BPS        115200      baud rate
//  CLK        25_000_000  i_clk frequency, Hz
//  DATA_BIT   8           data bits per frame (6, 7, 8)
//  STOP_BIT   1           stop bits per frame (integer >= 1)
// PORTS
//  i_clk        in   1         system clock; all logic on rising edge
//  i_reset_n    in   1         synchronous reset, active low
//  i_rxd        in   1         async serial line, idle high
//  o_data       out  DATA_BIT  received word, LSB = first data bit on line
//  o_valid      out  1         one-cycle pulse: o_data/o_check_err/o_frame_err valid
//  o_check_err  out  1         parity mismatch on the frame flagged by o_valid
//  o_frame_err  out  1         a stop bit sampled low on the frame flagged by o_valid
// BEHAVIOUR
//  - One clock; reset is synchronous and active-low (i_reset_n sampled on i_clk rising).
//  - Reset: o_data=0, o_valid=0, o_check_err=0, o_frame_err=0, FSM=IDLE, counters=0,
//    synchroniser regs=1. Reset mid-frame aborts the frame silently (no o_valid).
//  - i_rxd passes a 2-FF synchroniser (sync value rxd_s); edge detect uses a third FF.
//  - Bit period P = CLK/BPS (integer division; 217 at defaults); HALF = P/2.
//    Baud counter width from a log2 function of P; counter runs 0..P-1, reset on frame start.
//  - FSM states: IDLE, START, DATA, CHECK, STOP, BREAK.
//    IDLE : on rxd_s falling edge (1->0) clear baud cnt -> START.
//    START: at cnt==HALF sample rxd_s; 0 -> restart cnt, go DATA; 1 -> glitch, back to IDLE.
//    DATA : every P cycles after start mid-point sample rxd_s into shift reg (LSB first);
//           after DATA_BIT samples -> CHECK if CHECK_BIT!="None", else STOP.
//    CHECK: one sample P after last data sample; stores parity bit.
//    STOP : STOP_BIT samples, each P apart. Any 0 sample sets frame error.
//           After last stop sample: load o_data, o_check_err, o_frame_err; pulse o_valid
//           next cycle (1 cycle). Then IDLE if final stop sample was 1, else BREAK.
//    BREAK: wait for rxd_s==1, then IDLE (no start detect while line held low).
//  - Parity: Odd requires XOR(data,parity)==1; Even requires ==0; "None" -> o_check_err=0.
//  - Latency: o_valid rises 1 cycle after mid-point sample of last stop bit.
//  - o_data and error flags hold until the next o_valid; o_valid never >1 cycle wide.
//  - No backpressure: consumer must accept on the pulse; back-to-back frames (next start
//    edge right after stop bit) must be received without loss.
//  - Sampling at mid-bit tolerates >=±3% baud mismatch at 8N1.
//  - Unknown CHECK_BIT string treated as "None".
// TESTING
//  1 Defaults, send 8N1 0xA5 (LSB first, P=217) -> one o_valid, o_data=8'hA5, errors 0.
//  2 CHECK_BIT="Even", send 0x03 with parity 1 -> o_valid, o_check_err=1; with parity 0 -> 0.
//  3 Low glitch of 50 cycles on idle line -> no o_valid, FSM back in IDLE, next 0x5A received.
//  4 Send 0x3C with stop bit 0 then line held low 3000 cycles -> o_valid, o_frame_err=1;
//    no further o_valid until line high; following 0xC3 received cleanly.
//  5 uart_tx loopback, defaults, 256 back-to-back words 0x00..0xFF -> all received in order.
//  6 Assert i_reset_n=0 mid DATA of a frame -> no o_valid, outputs 0; next frame 0x81 ok.

Source files
------------

// File: rtl/uart_rx_if.sv
// Output bundle of the UART receiver: recovered word plus per-frame status.
// Latency: none, this is a plain signal bundle.
// Backpressure: none; the consumer must take the word on the o_valid pulse.
interface uart_rx_if #(
  parameter int DATA_BIT = 8
);
  logic [DATA_BIT-1:0] o_data;
  logic                o_valid;
  logic                o_check_err;
  logic                o_frame_err;

  // Receiver side drives the bundle.
  modport master (output o_data, output o_valid, output o_check_err, output o_frame_err);
  // Consumer side observes it.
  modport slave  (input  o_data, input  o_valid, input  o_check_err, input  o_frame_err);
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 2-FF synchroniser, start detect, mid-bit sampling, parity/stop check.
// Latency: o_valid rises 1 cycle after the mid-point sample of the last stop bit.
// Backpressure: none; each word is presented for exactly one cycle.
module uart_rx #(
  parameter string CHECK_BIT = "None",
  parameter int    BPS       = 115200,
  parameter int    CLK       = 25_000_000,
  parameter int    DATA_BIT  = 8,
  parameter int    STOP_BIT  = 1
) (
  input  logic      i_clk,
  input  logic      i_reset_n,
  input  logic      i_rxd,
  uart_rx_if.master rx_if
);

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

  localparam int P    = CLK / BPS;
  localparam int HALF = P / 2;
  localparam int CW   = clog2(P);
  localparam int BMAX = (DATA_BIT > STOP_BIT) ? DATA_BIT : STOP_BIT;
  localparam int BW   = clog2(BMAX + 1);

  // Any string other than "Odd"/"Even" disables parity.
  localparam bit PAR_ODD  = (CHECK_BIT == "Odd");
  localparam bit PAR_EVEN = (CHECK_BIT == "Even");
  localparam bit PAR_EN   = PAR_ODD | PAR_EVEN;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_CHECK, S_STOP, S_BREAK} state_t;

  state_t              state_q, state_d;
  logic                rxd_meta_q, rxd_meta_d;
  logic                rxd_s_q, rxd_s_d;
  logic                rxd_p_q, rxd_p_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_BIT-1:0] shift_q, shift_d;
  logic                par_q, par_d;
  logic                ferr_acc_q, ferr_acc_d;
  logic [DATA_BIT-1:0] data_q, data_d;
  logic                valid_q, valid_d;
  logic                cerr_q, cerr_d;
  logic                ferr_q, ferr_d;

  logic fall;
  logic cnt_last;
  logic par_bad;

  // Next-state logic for the synchroniser, bit timing and frame FSM.
  always_comb begin
    rxd_meta_d = i_rxd;
    rxd_s_d    = rxd_meta_q;
    rxd_p_d    = rxd_s_q;
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    ferr_acc_d = ferr_acc_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    cerr_d     = cerr_q;
    ferr_d     = ferr_q;

    fall     = rxd_p_q & ~rxd_s_q;
    cnt_last = (cnt_q == CW'(P - 1));
    if (PAR_ODD)       par_bad = ~(^{shift_q, par_q});
    else if (PAR_EVEN) par_bad = ^{shift_q, par_q};
    else               par_bad = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (fall) begin
          cnt_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_q == CW'(HALF)) begin
          if (!rxd_s_q) begin
            cnt_d      = '0;
            bit_cnt_d  = '0;
            ferr_acc_d = 1'b0;
            state_d    = S_DATA;
          end else begin
            state_d = S_IDLE;   // start bit did not survive to mid-bit: glitch
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (cnt_last) begin
          cnt_d   = '0;
          shift_d = {rxd_s_q, shift_q[DATA_BIT-1:1]};
          if (bit_cnt_q == BW'(DATA_BIT - 1)) begin
            bit_cnt_d = '0;
            state_d   = PAR_EN ? S_CHECK : S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_CHECK: begin
        if (cnt_last) begin
          cnt_d   = '0;
          par_d   = rxd_s_q;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        if (cnt_last) begin
          cnt_d = '0;
          if (!rxd_s_q) ferr_acc_d = 1'b1;
          if (bit_cnt_q == BW'(STOP_BIT - 1)) begin
            bit_cnt_d = '0;
            data_d    = shift_q;
            cerr_d    = par_bad;
            ferr_d    = ferr_acc_q | ~rxd_s_q;
            valid_d   = 1'b1;
            // A low final stop bit means the line may be in a break; wait for idle.
            state_d   = rxd_s_q ? S_IDLE : S_BREAK;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_BREAK: begin
        if (rxd_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs, synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q    <= S_IDLE;
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
      rxd_p_q    <= 1'b1;
      cnt_q      <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      ferr_acc_q <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      cerr_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rxd_meta_q <= rxd_meta_d;
      rxd_s_q    <= rxd_s_d;
      rxd_p_q    <= rxd_p_d;
      cnt_q      <= cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      ferr_acc_q <= ferr_acc_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      cerr_q     <= cerr_d;
      ferr_q     <= ferr_d;
    end
  end

  assign rx_if.o_data      = data_q;
  assign rx_if.o_valid     = valid_q;
  assign rx_if.o_check_err = cerr_q;
  assign rx_if.o_frame_err = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: default 8N1 instance at P=217 and an 8E1 instance at P=8.
// Expected words are queued when a frame is driven and popped on each o_valid.
// Stray or widened o_valid pulses and leftover expectations count as mismatches.
module tb_uart_rx;

  localparam int PA = 25_000_000 / 115200;   // 217
  localparam int PB = 800_000 / 100_000;     // 8

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rxd_a = 1'b1;
  logic rxd_b = 1'b1;

  int n_cmp = 0;
  int n_err = 0;

  // {data, check_err, frame_err}
  logic [9:0] qa[$];
  logic [9:0] qb[$];
  logic [9:0] ea, eb;
  logic       va_prev = 1'b0;
  logic       vb_prev = 1'b0;

  always #5 clk = ~clk;

  uart_rx_if #(.DATA_BIT(8)) ifa ();
  uart_rx_if #(.DATA_BIT(8)) ifb ();

  uart_rx dut_a (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .i_rxd     (rxd_a),
    .rx_if     (ifa.master)
  );

  uart_rx #(
    .CHECK_BIT ("Even"),
    .BPS       (100_000),
    .CLK       (800_000),
    .DATA_BIT  (8),
    .STOP_BIT  (1)
  ) dut_b (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .i_rxd     (rxd_b),
    .rx_if     (ifb.master)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic bit_a(input logic v);
    rxd_a = v;
    repeat (PA) @(negedge clk);
  endtask

  task automatic bit_b(input logic v);
    rxd_b = v;
    repeat (PB) @(negedge clk);
  endtask

  // 8N1 frame on instance A; stop_v=0 models a framing error.
  task automatic send_a(input logic [7:0] d, input logic stop_v);
    qa.push_back({d, 1'b0, ~stop_v});
    bit_a(1'b0);
    for (int i = 0; i < 8; i++) bit_a(d[i]);
    bit_a(stop_v);
  endtask

  // 8E1 frame on instance B with an explicit parity bit.
  task automatic send_b(input logic [7:0] d, input logic p);
    qb.push_back({d, (^d) ^ p, 1'b0});
    bit_b(1'b0);
    for (int i = 0; i < 8; i++) bit_b(d[i]);
    bit_b(p);
    bit_b(1'b1);
  endtask

  // Scoreboard for instance A.
  always @(negedge clk) begin
    if (ifa.o_valid) begin
      check("a_valid_width", {31'd0, va_prev}, 32'd0);
      if (qa.size() == 0) begin
        check("a_unexpected_valid", 32'd1, 32'd0);
      end else begin
        ea = qa.pop_front();
        check("a_data",      {24'd0, ifa.o_data},      {24'd0, ea[9:2]});
        check("a_check_err", {31'd0, ifa.o_check_err}, {31'd0, ea[1]});
        check("a_frame_err", {31'd0, ifa.o_frame_err}, {31'd0, ea[0]});
      end
    end
    va_prev <= ifa.o_valid;
  end

  // Scoreboard for instance B.
  always @(negedge clk) begin
    if (ifb.o_valid) begin
      check("b_valid_width", {31'd0, vb_prev}, 32'd0);
      if (qb.size() == 0) begin
        check("b_unexpected_valid", 32'd1, 32'd0);
      end else begin
        eb = qb.pop_front();
        check("b_data",      {24'd0, ifb.o_data},      {24'd0, eb[9:2]});
        check("b_check_err", {31'd0, ifb.o_check_err}, {31'd0, eb[1]});
        check("b_frame_err", {31'd0, ifb.o_frame_err}, {31'd0, eb[0]});
      end
    end
    vb_prev <= ifb.o_valid;
  end

  initial begin
    repeat (5) @(negedge clk);
    check("rst_a_data",  {24'd0, ifa.o_data}, 32'd0);
    check("rst_a_valid", {31'd0, ifa.o_valid}, 32'd0);
    check("rst_a_cerr",  {31'd0, ifa.o_check_err}, 32'd0);
    check("rst_a_ferr",  {31'd0, ifa.o_frame_err}, 32'd0);
    check("rst_b_data",  {24'd0, ifb.o_data}, 32'd0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // Basic 8N1 word.
    send_a(8'hA5, 1'b1);
    repeat (2 * PA) @(negedge clk);
    check("a_q_after_a5", qa.size(), 32'd0);

    // Short low glitch on an idle line must be rejected.
    rxd_a = 1'b0;
    repeat (50) @(negedge clk);
    rxd_a = 1'b1;
    repeat (2 * PA) @(negedge clk);
    send_a(8'h5A, 1'b1);
    repeat (2 * PA) @(negedge clk);

    // Framing error followed by a held-low line (break).
    send_a(8'h3C, 1'b0);
    repeat (3000) @(negedge clk);
    check("a_q_in_break", qa.size(), 32'd0);
    rxd_a = 1'b1;
    repeat (2 * PA) @(negedge clk);
    send_a(8'hC3, 1'b1);
    repeat (2 * PA) @(negedge clk);

    // Even parity: bad then good parity bit.
    send_b(8'h03, 1'b1);
    send_b(8'h03, 1'b0);
    repeat (2 * PB) @(negedge clk);

    // 256 back-to-back words with correct parity.
    for (int w = 0; w < 256; w++) send_b(w[7:0], ^w[7:0]);
    repeat (4 * PB) @(negedge clk);
    check("b_q_after_burst", qb.size(), 32'd0);

    // Reset in the middle of a frame's data bits (line high, so no new edges).
    bit_a(1'b0);
    bit_a(1'b1);
    bit_a(1'b1);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (8 * PA) @(negedge clk);
    check("midrst_a_data",  {24'd0, ifa.o_data}, 32'd0);
    check("midrst_a_cerr",  {31'd0, ifa.o_check_err}, 32'd0);
    check("midrst_a_ferr",  {31'd0, ifa.o_frame_err}, 32'd0);
    check("midrst_b_data",  {24'd0, ifb.o_data}, 32'd0);
    send_a(8'h81, 1'b1);
    repeat (2 * PA) @(negedge clk);

    check("final_qa_empty", qa.size(), 32'd0);
    check("final_qb_empty", qb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
